// File: rtl/dallanma_cozucu.sv
// Branch resolution unit: tracks predicted control-flow instructions in order, checks each
// prediction against the execute outcome, drives the predictor update bus and redirects fetch.
module dallanma_cozucu #(
  parameter int XLEN            = 32,
  parameter int DERINLIK        = 8,
  parameter int TEMIZLE_GECIKME = 2
) (
  input  logic            clk_g,
  input  logic            rst_g,
  input  logic            i_ongoru_gecerli,
  input  logic [XLEN-1:0] i_ongoru_adres,
  input  logic [XLEN-1:0] i_ongoru_buyruk,
  input  logic            i_ongoru_atladi,
  input  logic [XLEN-1:0] i_ongoru_hedef,
  output logic            o_dolu,
  input  logic            i_coz_gecerli,
  input  logic            i_coz_atladi,
  input  logic [XLEN-1:0] i_coz_hedef,
  output logic            o_guncelle_gecerli,
  output logic [XLEN-1:0] o_eski_buyruk,
  output logic [XLEN-1:0] o_eski_buyruk_adresi,
  output logic            o_buyruk_atladi,
  output logic [XLEN-1:0] o_atlanan_adres,
  output logic            o_ongoru_yanlis,
  output logic            o_yonlendir,
  output logic [XLEN-1:0] o_yonlendir_adres,
  output logic            o_tasma,
  output logic [31:0]     o_toplam_sayac,
  output logic [31:0]     o_yanlis_sayac
);

  localparam int AW = $clog2(DERINLIK);
  localparam int TW = $clog2(TEMIZLE_GECIKME + 2);
  localparam logic [AW:0] DOLU_SAYI = (AW+1)'(DERINLIK);
  localparam logic [TW-1:0] GECIKME = TW'(TEMIZLE_GECIKME);

  typedef enum logic {NORMAL, TEMIZLE} durum_t;

  durum_t          r_durum;
  logic [TW-1:0]   r_temizle_sayac;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_sayi;
  logic [XLEN-1:0] r_adres  [DERINLIK];
  logic [XLEN-1:0] r_buyruk [DERINLIK];
  logic            r_atladi [DERINLIK];
  logic [XLEN-1:0] r_hedef  [DERINLIK];

  logic            w_dolu;
  logic            w_bos;
  logic            w_normal;
  logic            w_pop;
  logic            w_push;
  logic            w_yanlis;
  logic            w_kosullu;
  logic [XLEN-1:0] w_h_adres;
  logic [XLEN-1:0] w_h_buyruk;
  logic            w_h_atladi;
  logic [XLEN-1:0] w_h_hedef;
  logic [XLEN-1:0] w_yon_adres;

  assign w_dolu     = (r_sayi == DOLU_SAYI);
  assign w_bos      = (r_sayi == '0);
  assign w_normal   = (r_durum == NORMAL);
  assign w_h_adres  = r_adres[r_rptr];
  assign w_h_buyruk = r_buyruk[r_rptr];
  assign w_h_atladi = r_atladi[r_rptr];
  assign w_h_hedef  = r_hedef[r_rptr];
  assign w_kosullu  = (w_h_buyruk[6:0] == 7'b1100011);
  assign w_pop      = i_coz_gecerli && w_normal && !w_bos;

  // Conditional branches also compare direction; everything else is judged on target alone.
  assign w_yanlis = w_pop && (w_kosullu ?
                    ((w_h_atladi != i_coz_atladi) || (i_coz_atladi && (w_h_hedef != i_coz_hedef))) :
                    (w_h_hedef != i_coz_hedef));

  // A push at full is only possible when the head leaves in the same cycle; a flush drops it.
  assign w_push = i_ongoru_gecerli && w_normal && (!w_dolu || w_pop) && !w_yanlis;

  assign w_yon_adres = i_coz_atladi ? i_coz_hedef :
                       (w_h_adres + ((w_h_buyruk[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4)));

  assign o_dolu = w_dolu || (r_durum == TEMIZLE);

  always_ff @(posedge clk_g) begin
    if (w_push) begin
      r_adres[r_wptr]  <= i_ongoru_adres;
      r_buyruk[r_wptr] <= i_ongoru_buyruk;
      r_atladi[r_wptr] <= i_ongoru_atladi;
      r_hedef[r_wptr]  <= i_ongoru_hedef;
    end
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      r_durum              <= NORMAL;
      r_temizle_sayac      <= '0;
      r_wptr               <= '0;
      r_rptr               <= '0;
      r_sayi               <= '0;
      o_guncelle_gecerli   <= 1'b0;
      o_eski_buyruk        <= '0;
      o_eski_buyruk_adresi <= '0;
      o_buyruk_atladi      <= 1'b0;
      o_atlanan_adres      <= '0;
      o_ongoru_yanlis      <= 1'b0;
      o_yonlendir          <= 1'b0;
      o_yonlendir_adres    <= '0;
      o_tasma              <= 1'b0;
      o_toplam_sayac       <= '0;
      o_yanlis_sayac       <= '0;
    end else begin
      o_guncelle_gecerli <= w_pop;
      o_ongoru_yanlis    <= w_yanlis;
      o_yonlendir        <= w_yanlis;
      if (w_pop) begin
        o_eski_buyruk        <= w_h_buyruk;
        o_eski_buyruk_adresi <= w_h_adres;
        o_buyruk_atladi      <= i_coz_atladi;
        o_atlanan_adres      <= i_coz_hedef;
        if (o_toplam_sayac != '1) o_toplam_sayac <= o_toplam_sayac + 32'd1;
      end
      if (w_yanlis) begin
        o_yonlendir_adres <= w_yon_adres;
        if (o_yanlis_sayac != '1) o_yanlis_sayac <= o_yanlis_sayac + 32'd1;
      end
      // Overflow only counts in NORMAL; traffic during the flush window is dropped quietly.
      if ((i_ongoru_gecerli && w_normal && w_dolu && !w_pop) ||
          (i_coz_gecerli && w_normal && w_bos))
        o_tasma <= 1'b1;

      case (r_durum)
        NORMAL: begin
          if (w_yanlis) begin
            r_durum         <= TEMIZLE;
            r_temizle_sayac <= GECIKME;
          end
        end
        TEMIZLE: begin
          if (r_temizle_sayac <= TW'(1)) begin
            r_durum         <= NORMAL;
            r_temizle_sayac <= '0;
          end else begin
            r_temizle_sayac <= r_temizle_sayac - TW'(1);
          end
        end
        default: r_durum <= NORMAL;
      endcase

      if (w_yanlis) begin
        r_rptr <= r_wptr;
        r_sayi <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_push && !w_pop)      r_sayi <= r_sayi + (AW+1)'(1);
        else if (w_pop && !w_push) r_sayi <= r_sayi - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Scoreboard bench for dallanma_cozucu: a prediction queue models the FIFO, and expected
// update-bus beats are queued at resolve time and checked when the DUT emits them.
module tb_dallanma_cozucu;

  localparam int DER = 8;
  localparam logic [31:0] BEQ  = 32'h0020_8063;
  localparam logic [31:0] JALR = 32'h0005_00E7;
  localparam logic [31:0] CBR  = 32'h0000_C001;

  typedef struct {
    logic [31:0] adres;
    logic [31:0] buyruk;
    logic        atladi;
    logic [31:0] hedef;
  } pred_t;

  typedef struct {
    logic [31:0] buyruk;
    logic [31:0] adres;
    logic        atladi;
    logic [31:0] hedef;
    logic        yanlis;
    logic [31:0] yon_adres;
    int          due;
  } sb_t;

  logic        clk_g = 1'b0;
  logic        rst_g = 1'b1;
  logic        i_ongoru_gecerli = 1'b0;
  logic [31:0] i_ongoru_adres = '0;
  logic [31:0] i_ongoru_buyruk = '0;
  logic        i_ongoru_atladi = 1'b0;
  logic [31:0] i_ongoru_hedef = '0;
  logic        i_coz_gecerli = 1'b0;
  logic        i_coz_atladi = 1'b0;
  logic [31:0] i_coz_hedef = '0;
  logic        o_dolu, o_guncelle_gecerli, o_buyruk_atladi, o_ongoru_yanlis, o_yonlendir, o_tasma;
  logic [31:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres, o_yonlendir_adres;
  logic [31:0] o_toplam_sayac, o_yanlis_sayac;

  pred_t mq[$];
  sb_t   sb[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    expTotal = 0;
  int    expYanlis = 0;

  dallanma_cozucu #(.XLEN(32), .DERINLIK(DER), .TEMIZLE_GECIKME(2)) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .i_ongoru_gecerli(i_ongoru_gecerli), .i_ongoru_adres(i_ongoru_adres),
    .i_ongoru_buyruk(i_ongoru_buyruk), .i_ongoru_atladi(i_ongoru_atladi),
    .i_ongoru_hedef(i_ongoru_hedef), .o_dolu(o_dolu),
    .i_coz_gecerli(i_coz_gecerli), .i_coz_atladi(i_coz_atladi), .i_coz_hedef(i_coz_hedef),
    .o_guncelle_gecerli(o_guncelle_gecerli), .o_eski_buyruk(o_eski_buyruk),
    .o_eski_buyruk_adresi(o_eski_buyruk_adresi), .o_buyruk_atladi(o_buyruk_atladi),
    .o_atlanan_adres(o_atlanan_adres), .o_ongoru_yanlis(o_ongoru_yanlis),
    .o_yonlendir(o_yonlendir), .o_yonlendir_adres(o_yonlendir_adres), .o_tasma(o_tasma),
    .o_toplam_sayac(o_toplam_sayac), .o_yanlis_sayac(o_yanlis_sayac)
  );

  always #5 clk_g = ~clk_g;
  always @(posedge clk_g) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Reference behaviour for one resolve of the given prediction.
  function automatic sb_t predict(pred_t p, logic a, logic [31:0] h);
    sb_t e;
    e.buyruk = p.buyruk;
    e.adres  = p.adres;
    e.atladi = a;
    e.hedef  = h;
    if (p.buyruk[6:0] == 7'b1100011) e.yanlis = (p.atladi != a) || (a && (p.hedef != h));
    else                             e.yanlis = (p.hedef != h);
    if (a) e.yon_adres = h;
    else   e.yon_adres = p.adres + ((p.buyruk[1:0] != 2'b11) ? 32'd2 : 32'd4);
    e.due = cyc + 1;
    return e;
  endfunction

  // Update-bus monitor: pops the scoreboard on each beat and flags late or missing beats.
  sb_t me;
  always @(negedge clk_g) begin
    if (!rst_g) begin
      if (o_guncelle_gecerli) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_update pc=%h (no beat expected)", o_eski_buyruk_adresi);
        end else begin
          me = sb.pop_front();
          if (cyc != me.due) begin
            n_fail++;
            $display("[TB] FAIL update_latency cycle=%0d required=%0d", cyc, me.due);
          end
          n_chk++;
          if ({o_eski_buyruk, o_eski_buyruk_adresi, o_buyruk_atladi, o_atlanan_adres} !==
              {me.buyruk, me.adres, me.atladi, me.hedef}) begin
            n_fail++;
            $display("[TB] FAIL update_data got=%h/%h/%b/%h required=%h/%h/%b/%h",
                     o_eski_buyruk, o_eski_buyruk_adresi, o_buyruk_atladi, o_atlanan_adres,
                     me.buyruk, me.adres, me.atladi, me.hedef);
          end
          n_chk++;
          if (o_ongoru_yanlis !== me.yanlis || o_yonlendir !== me.yanlis) begin
            n_fail++;
            $display("[TB] FAIL yanlis_flag pc=%h got yanlis=%b yonlendir=%b required=%b",
                     me.adres, o_ongoru_yanlis, o_yonlendir, me.yanlis);
          end
          if (me.yanlis) begin
            n_chk++;
            if (o_yonlendir_adres !== me.yon_adres) begin
              n_fail++;
              $display("[TB] FAIL redirect_addr pc=%h got=%h required=%h",
                       me.adres, o_yonlendir_adres, me.yon_adres);
            end
          end
        end
      end else begin
        n_chk++;
        if (o_yonlendir !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stray_redirect got=%b required=0", o_yonlendir);
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          n_chk++;
          n_fail++;
          $display("[TB] FAIL missing_update pc=%h got=none required=beat", sb[0].adres);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_g);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] b, input logic t, input logic [31:0] h);
    i_ongoru_gecerli = 1'b1;
    i_ongoru_adres   = a;
    i_ongoru_buyruk  = b;
    i_ongoru_atladi  = t;
    i_ongoru_hedef   = h;
    if (mq.size() < DER) mq.push_back('{a, b, t, h});
    tick();
    i_ongoru_gecerli = 1'b0;
  endtask

  task automatic res(input logic a, input logic [31:0] h, output logic mis);
    pred_t p;
    sb_t   e;
    p = mq.pop_front();
    e = predict(p, a, h);
    sb.push_back(e);
    expTotal++;
    mis = e.yanlis;
    if (e.yanlis) begin
      expYanlis++;
      mq.delete();
    end
    i_coz_gecerli = 1'b1;
    i_coz_atladi  = a;
    i_coz_hedef   = h;
    tick();
    i_coz_gecerli = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_chk++;
    if ({o_dolu, o_guncelle_gecerli, o_tasma, o_yonlendir, o_ongoru_yanlis} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got=%b required=00000",
               {o_dolu, o_guncelle_gecerli, o_tasma, o_yonlendir, o_ongoru_yanlis});
    end
    n_chk++;
    if ({o_toplam_sayac, o_yanlis_sayac, o_yonlendir_adres} !== 96'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs got=%h/%h/%h required=0",
               o_toplam_sayac, o_yanlis_sayac, o_yonlendir_adres);
    end
    rst_g = 1'b0;
    tick();
    n_chk++;
    if (o_dolu !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL dolu_after_reset got=%b required=0", o_dolu);
    end
  endtask

  task automatic test_correct_branch();
    logic mis;
    enq(32'h100, BEQ, 1'b1, 32'h180);
    res(1'b1, 32'h180, mis);
    n_chk++;
    if (o_toplam_sayac !== 32'(expTotal) || o_yanlis_sayac !== 32'(expYanlis)) begin
      n_fail++;
      $display("[TB] FAIL correct_counters got=%0d/%0d required=%0d/%0d",
               o_toplam_sayac, o_yanlis_sayac, expTotal, expYanlis);
    end
    tick();
    n_chk++;
    if (o_guncelle_gecerli !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL guncelle_pulse got=%b required=0", o_guncelle_gecerli);
    end
  endtask

  task automatic test_mispredict();
    logic mis;
    enq(32'h200, BEQ, 1'b0, 32'h204);
    res(1'b1, 32'h240, mis);
    n_chk++;
    if (o_dolu !== 1'b1 || o_yanlis_sayac !== 32'(expYanlis)) begin
      n_fail++;
      $display("[TB] FAIL mispredict_enter got dolu=%b yanlis=%0d required 1/%0d",
               o_dolu, o_yanlis_sayac, expYanlis);
    end
    // Traffic inside the flush window must be ignored without raising overflow.
    i_ongoru_gecerli = 1'b1;
    i_ongoru_adres   = 32'h2F0;
    i_ongoru_buyruk  = BEQ;
    i_coz_gecerli    = 1'b1;
    i_coz_atladi     = 1'b0;
    tick();
    i_ongoru_gecerli = 1'b0;
    i_coz_gecerli    = 1'b0;
    n_chk++;
    if (o_dolu !== 1'b1 || o_tasma !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL temizle_second got dolu=%b tasma=%b required 1/0", o_dolu, o_tasma);
    end
    tick();
    n_chk++;
    if (o_dolu !== 1'b0 || o_toplam_sayac !== 32'(expTotal)) begin
      n_fail++;
      $display("[TB] FAIL temizle_exit got dolu=%b toplam=%0d required 0/%0d",
               o_dolu, o_toplam_sayac, expTotal);
    end
    // FIFO must be empty: a resolve now is an underflow.
    i_coz_gecerli = 1'b1;
    tick();
    i_coz_gecerli = 1'b0;
    n_chk++;
    if (o_tasma !== 1'b1 || o_toplam_sayac !== 32'(expTotal)) begin
      n_fail++;
      $display("[TB] FAIL empty_resolve got tasma=%b toplam=%0d required 1/%0d",
               o_tasma, o_toplam_sayac, expTotal);
    end
    enq(32'h280, BEQ, 1'b1, 32'h2C0);
    res(1'b0, 32'h284, mis);
    repeat (2) tick();
  endtask

  task automatic test_compressed();
    logic mis;
    enq(32'h300, CBR, 1'b1, 32'h320);
    res(1'b0, 32'h302, mis);
    repeat (2) tick();
    enq(32'hFFFF_FFFE, CBR, 1'b1, 32'h10);
    res(1'b0, 32'h0, mis);
    repeat (2) tick();
    n_chk++;
    if (o_dolu !== 1'b0 || o_yanlis_sayac !== 32'(expYanlis)) begin
      n_fail++;
      $display("[TB] FAIL compressed_end got dolu=%b yanlis=%0d required 0/%0d",
               o_dolu, o_yanlis_sayac, expYanlis);
    end
  endtask

  task automatic test_full_wrap();
    logic  mis;
    pred_t p;
    sb_t   e;
    rst_g = 1'b1;
    tick();
    rst_g = 1'b0;
    mq.delete();
    sb.delete();
    expTotal  = 0;
    expYanlis = 0;
    tick();
    for (int i = 0; i < DER; i++) begin
      enq(32'h1000 + 32'(i * 4), BEQ, i[0], 32'h2000 + 32'(i * 16));
      if (i == DER - 2) begin
        n_chk++;
        if (o_dolu !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL dolu_early got=%b required=0", o_dolu);
        end
      end
    end
    n_chk++;
    if (o_dolu !== 1'b1 || o_tasma !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_flags got dolu=%b tasma=%b required 1/0", o_dolu, o_tasma);
    end
    enq(32'h1100, BEQ, 1'b0, 32'h1104);
    n_chk++;
    if (o_tasma !== 1'b1 || o_dolu !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow got tasma=%b dolu=%b required 1/1", o_tasma, o_dolu);
    end
    // Simultaneous push and pop while full.
    p = mq.pop_front();
    e = predict(p, p.atladi, p.hedef);
    sb.push_back(e);
    expTotal++;
    mq.push_back('{32'h1200, BEQ, 1'b1, 32'h1300});
    i_ongoru_gecerli = 1'b1;
    i_ongoru_adres   = 32'h1200;
    i_ongoru_buyruk  = BEQ;
    i_ongoru_atladi  = 1'b1;
    i_ongoru_hedef   = 32'h1300;
    i_coz_gecerli    = 1'b1;
    i_coz_atladi     = p.atladi;
    i_coz_hedef      = p.hedef;
    tick();
    i_ongoru_gecerli = 1'b0;
    i_coz_gecerli    = 1'b0;
    n_chk++;
    if (o_dolu !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pushpop_full got dolu=%b required=1", o_dolu);
    end
    while (mq.size() > 0) begin
      p = mq[0];
      res(p.atladi, p.hedef, mis);
    end
    tick();
    n_chk++;
    if (o_dolu !== 1'b0 || o_toplam_sayac !== 32'(expTotal)) begin
      n_fail++;
      $display("[TB] FAIL drain got dolu=%b toplam=%0d required 0/%0d",
               o_dolu, o_toplam_sayac, expTotal);
    end
  endtask

  task automatic test_jalr();
    logic mis;
    enq(32'h400, JALR, 1'b1, 32'h500);
    res(1'b1, 32'h504, mis);
    n_chk++;
    if (o_yanlis_sayac !== 32'(expYanlis) || o_dolu !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL jalr got yanlis=%0d dolu=%b required %0d/1",
               o_yanlis_sayac, o_dolu, expYanlis);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic        mis;
    logic        a;
    logic [31:0] h;
    logic [31:0] b;
    pred_t       p;
    int          n;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0:       b = BEQ;
          1:       b = JALR;
          default: b = CBR;
        endcase
        enq($urandom & 32'hFFFF_FFFE, b, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE);
      end
      while (mq.size() > 0) begin
        p = mq[0];
        if ($urandom_range(0, 2) != 0) begin
          a = p.atladi;
          h = p.hedef;
        end else begin
          a = 1'($urandom_range(0, 1));
          h = $urandom & 32'hFFFF_FFFE;
        end
        res(a, h, mis);
        if (mis) begin
          repeat (2) tick();
          n_chk++;
          if (o_dolu !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL random_flush_exit got dolu=%b required=0", o_dolu);
          end
        end
      end
    end
    tick();
    n_chk++;
    if (o_toplam_sayac !== 32'(expTotal) || o_yanlis_sayac !== 32'(expYanlis)) begin
      n_fail++;
      $display("[TB] FAIL random_counters got=%0d/%0d required=%0d/%0d",
               o_toplam_sayac, o_yanlis_sayac, expTotal, expYanlis);
    end
  endtask

  task automatic test_reset_in_flush();
    logic mis;
    enq(32'h600, BEQ, 1'b0, 32'h604);
    res(1'b1, 32'h640, mis);
    n_chk++;
    if (o_yonlendir !== 1'b1 || o_dolu !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset got yonlendir=%b dolu=%b required 1/1", o_yonlendir, o_dolu);
    end
    sb.delete();
    #1;
    rst_g = 1'b1;
    #1;
    n_chk++;
    if ({o_guncelle_gecerli, o_yonlendir, o_ongoru_yanlis, o_dolu, o_tasma} !== 5'b0 ||
        {o_toplam_sayac, o_yanlis_sayac, o_yonlendir_adres} !== 96'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset got flags=%b regs=%h/%h/%h required 0",
               {o_guncelle_gecerli, o_yonlendir, o_ongoru_yanlis, o_dolu, o_tasma},
               o_toplam_sayac, o_yanlis_sayac, o_yonlendir_adres);
    end
    tick();
    rst_g = 1'b0;
    mq.delete();
    expTotal  = 0;
    expYanlis = 0;
    tick();
    enq(32'h700, BEQ, 1'b1, 32'h780);
    res(1'b1, 32'h780, mis);
    tick();
    n_chk++;
    if (o_toplam_sayac !== 32'd1 || o_yanlis_sayac !== 32'd0 || o_dolu !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset got toplam=%0d yanlis=%0d dolu=%b required 1/0/0",
               o_toplam_sayac, o_yanlis_sayac, o_dolu);
    end
  endtask

  initial begin
    test_reset();
    test_correct_branch();
    test_mispredict();
    test_compressed();
    test_full_wrap();
    test_jalr();
    test_random();
    test_reset_in_flush();
    repeat (3) tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover got=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
